// File: rtl/eject_sink_pkg.sv
// Shared field layout, sizing constants and enumerations for the ejection sink.
package eject_sink_pkg;

  localparam int unsigned ROUTER_BIT_SIZE = 4;
  localparam int unsigned MAX_VC          = 4;
  localparam int unsigned BUFFER_VC_W     = $clog2(MAX_VC);

  localparam int unsigned BUFFER_FULL_BIT = 0;
  localparam int unsigned BUFFER_VC_LSB   = 1;
  localparam int unsigned FLIT_HEAD_BIT   = BUFFER_VC_LSB + BUFFER_VC_W;
  localparam int unsigned FLIT_TAIL_BIT   = FLIT_HEAD_BIT + 1;
  localparam int unsigned FLIT_DST_LSB    = FLIT_TAIL_BIT + 1;

  localparam int unsigned PKT_CNT_W  = 10;
  localparam int unsigned FLIT_CNT_W = 16;
  localparam int unsigned CFG_DLY_W  = 4;
  localparam int unsigned ERR_W      = 2;

  // Low bits of the staging word, MSB first, matching the bit positions above.
  typedef struct packed {
    logic [ROUTER_BIT_SIZE-1:0] dst;
    logic                       tail;
    logic                       head;
    logic [BUFFER_VC_W-1:0]     vc;
    logic                       full;
  } flit_fields_t;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE         = 2'd0,
    ERR_NO_OPEN      = 2'd1,
    ERR_HEAD_IN_OPEN = 2'd2,
    ERR_BAD_DST      = 2'd3
  } err_code_e;

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_OPEN = 1'b1
  } vc_state_e;

endpackage

// File: rtl/eject_sink_credit_delay_line.sv
// Credit return pipeline: valid+vc shift register with a programmable output tap.
module credit_delay_line #(
  parameter int unsigned MAXDLY = 15,
  parameter int unsigned VC_W   = 2,
  localparam int unsigned DLY_W = $clog2(MAXDLY + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [VC_W-1:0] in_vc,
  input  logic [DLY_W-1:0] tap,
  output logic            out_valid,
  output logic [VC_W-1:0] out_vc
);

  localparam int unsigned STAGES = (MAXDLY > 1) ? MAXDLY - 1 : 1;

  logic            stage_valid [STAGES];
  logic [VC_W-1:0] stage_vc    [STAGES];
  logic            tap_valid;
  logic [VC_W-1:0] tap_vc;

  // The output register is itself the last stage, so a tap of d lands d cycles later.
  always_comb begin : tap_select
    tap_valid = in_valid;
    tap_vc    = in_vc;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (DLY_W'(i + 2) == tap) begin
        tap_valid = stage_valid[i];
        tap_vc    = stage_vc[i];
      end
    end
  end

  always_ff @(posedge clk) begin : shift_regs
    if (!rst_n || flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_valid[i] <= 1'b0;
        stage_vc[i]    <= '0;
      end
      out_valid <= 1'b0;
      out_vc    <= '0;
    end else begin
      stage_valid[0] <= in_valid;
      stage_vc[0]    <= in_vc;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_vc[i]    <= stage_vc[i-1];
      end
      out_valid <= tap_valid;
      out_vc    <= tap_valid ? tap_vc : '0;
    end
  end

endmodule

// File: rtl/eject_sink.sv
// Ejection sink: tracks per-VC packet framing, counts traffic, flags protocol errors
// and returns one delayed credit per accepted flit.
module eject_sink
  import eject_sink_pkg::*;
#(
  parameter int unsigned MAXVC  = MAX_VC,
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned MAXDLY = 15,
  localparam int unsigned VC_W  = $clog2(MAXVC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  input  logic [ROUTER_BIT_SIZE-1:0] cfg_my_id,
  input  logic [PKT_CNT_W-1:0]       cfg_num_pkt,
  input  logic [CFG_DLY_W-1:0]       cfg_credit_delay,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       cr_valid,
  output logic [VC_W-1:0]            cr_vc,
  output logic [PKT_CNT_W-1:0]       pkt_count,
  output logic [FLIT_CNT_W-1:0]      flit_count,
  output logic                       err,
  output logic [ERR_W-1:0]           err_code,
  output logic                       done
);

  localparam int unsigned FIELDS_W = $bits(flit_fields_t);
  localparam int unsigned DLY_W    = $clog2(MAXDLY + 1);

  flit_fields_t                flit;
  logic [FLIT_W-FIELDS_W-1:0]  unused_flit_hi;
  logic [VC_W-1:0]             vc;
  logic                        accept;

  vc_state_e                   state_q [MAXVC];
  vc_state_e                   state_d [MAXVC];
  logic                        pkt_inc;
  err_code_e                   flit_err;

  logic [ROUTER_BIT_SIZE-1:0]  my_id_q;
  logic [PKT_CNT_W-1:0]        num_pkt_q;
  logic [PKT_CNT_W-1:0]        num_pkt_d;
  logic [DLY_W-1:0]            dly_q;
  logic                        cfg_loaded_q;
  logic [PKT_CNT_W-1:0]        pkt_count_d;
  logic [FLIT_CNT_W-1:0]       flit_count_d;
  logic                        err_d;
  logic [ERR_W-1:0]            err_code_d;
  logic                        all_idle_d;
  logic                        done_d;

  assign flit           = flit_fields_t'(in_flit[FIELDS_W-1:0]);
  assign unused_flit_hi = in_flit[FLIT_W-1:FIELDS_W];
  assign vc             = VC_W'(flit.vc);
  assign accept         = flit.full && !cfg_valid;

  function automatic logic [DLY_W-1:0] clamp_dly(input logic [CFG_DLY_W-1:0] d);
    if (d == '0) return DLY_W'(1);
    if (32'(d) > MAXDLY) return DLY_W'(MAXDLY);
    return DLY_W'(d);
  endfunction

  always_ff @(posedge clk) begin : vc_state_reg
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAXVC; i++) state_q[i] <= VC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-VC framing; the destination check outranks the head-in-open check.
  always_comb begin : vc_fsm_next
    state_d  = state_q;
    pkt_inc  = 1'b0;
    flit_err = ERR_NONE;
    if (cfg_valid) begin
      for (int unsigned i = 0; i < MAXVC; i++) state_d[i] = VC_IDLE;
    end else if (accept) begin
      if (flit.head) begin
        if (state_q[vc] == VC_OPEN) flit_err = ERR_HEAD_IN_OPEN;
        if (flit.dst != my_id_q)    flit_err = ERR_BAD_DST;
        state_d[vc] = flit.tail ? VC_IDLE : VC_OPEN;
        pkt_inc     = flit.tail;
      end else if (state_q[vc] == VC_OPEN) begin
        if (flit.tail) begin
          state_d[vc] = VC_IDLE;
          pkt_inc     = 1'b1;
        end
      end else begin
        flit_err = ERR_NO_OPEN;
      end
    end
  end

  always_comb begin : ctrl_next
    pkt_count_d  = pkt_count;
    flit_count_d = flit_count;
    err_d        = err;
    err_code_d   = err_code;
    all_idle_d   = 1'b1;
    if (cfg_valid) begin
      pkt_count_d  = '0;
      flit_count_d = '0;
      err_d        = 1'b0;
      err_code_d   = ERR_NONE;
    end else begin
      if (pkt_inc && !(&pkt_count))  pkt_count_d  = pkt_count + PKT_CNT_W'(1);
      if (accept && !(&flit_count))  flit_count_d = flit_count + FLIT_CNT_W'(1);
      if (flit_err != ERR_NONE && !err) begin
        err_d      = 1'b1;
        err_code_d = flit_err;
      end
    end
    for (int unsigned i = 0; i < MAXVC; i++) begin
      if (state_d[i] != VC_IDLE) all_idle_d = 1'b0;
    end
    num_pkt_d = cfg_valid ? cfg_num_pkt : num_pkt_q;
    done_d    = (cfg_valid || cfg_loaded_q) && all_idle_d && (pkt_count_d == num_pkt_d);
  end

  always_ff @(posedge clk) begin : ctrl_regs
    if (!rst_n) begin
      my_id_q      <= '0;
      num_pkt_q    <= '0;
      dly_q        <= DLY_W'(1);
      cfg_loaded_q <= 1'b0;
      pkt_count    <= '0;
      flit_count   <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      done         <= 1'b0;
    end else begin
      if (cfg_valid) begin
        my_id_q      <= cfg_my_id;
        dly_q        <= clamp_dly(cfg_credit_delay);
        cfg_loaded_q <= 1'b1;
      end
      num_pkt_q  <= num_pkt_d;
      pkt_count  <= pkt_count_d;
      flit_count <= flit_count_d;
      err        <= err_d;
      err_code   <= err_code_d;
      done       <= done_d;
    end
  end

  credit_delay_line #(
    .MAXDLY (MAXDLY),
    .VC_W   (VC_W)
  ) u_credit_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (cfg_valid),
    .in_valid  (accept),
    .in_vc     (vc),
    .tap       (dly_q),
    .out_valid (cr_valid),
    .out_vc    (cr_vc)
  );

endmodule

// File: tb/tb_eject_sink.sv
// Randomized scoreboard bench for eject_sink against a packet-level reference model.
module tb_eject_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_my_id = '0;
  logic [9:0]  cfg_num_pkt = '0;
  logic [3:0]  cfg_credit_delay = '0;
  logic [31:0] in_flit = '0;
  logic        cr_valid;
  logic [1:0]  cr_vc;
  logic [9:0]  pkt_count;
  logic [15:0] flit_count;
  logic        err;
  logic [1:0]  err_code;
  logic        done;

  eject_sink dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_valid        (cfg_valid),
    .cfg_my_id        (cfg_my_id),
    .cfg_num_pkt      (cfg_num_pkt),
    .cfg_credit_delay (cfg_credit_delay),
    .in_flit          (in_flit),
    .cr_valid         (cr_valid),
    .cr_vc            (cr_vc),
    .pkt_count        (pkt_count),
    .flit_count       (flit_count),
    .err              (err),
    .err_code         (err_code),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int vc;
    int cyc;
  } cr_t;
  cr_t exp_q[$];

  // Reference model state
  int m_pkt, m_flit, m_code, m_num, m_dly, m_id;
  bit m_loaded;
  bit m_open [4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drop credits that a flush/reset at the upcoming edge will discard.
  task automatic prune(input int c);
    while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
  endtask

  always @(negedge clk) begin : credit_monitor
    cr_t e;
    if (cr_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL credit_unexpected: cr_valid=1 vc %0d at cycle %0d, none expected", cr_vc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("credit_vc", int'(cr_vc), e.vc);
        chk("credit_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL credit_missing: cr_valid=0 at cycle %0d, expected vc %0d at cycle %0d", cyc, e.vc, e.cyc);
    end
  end

  function automatic bit m_all_idle();
    for (int i = 0; i < 4; i++) if (m_open[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_pkt_count"}, int'(pkt_count), m_pkt);
    chk({tag, "_flit_count"}, int'(flit_count), m_flit);
    chk({tag, "_err"}, int'(err), int'(m_code != 0));
    chk({tag, "_err_code"}, int'(err_code), m_code);
    chk({tag, "_done"}, int'(done), int'(m_loaded && m_pkt == m_num && m_all_idle()));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_flit = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_clear();
    m_pkt = 0; m_flit = 0; m_code = 0;
    for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
  endtask

  task automatic cfg(input int id, input int num, input int dly);
    cfg_valid = 1'b1;
    cfg_my_id = 4'(id);
    cfg_num_pkt = 10'(num);
    cfg_credit_delay = 4'(dly);
    prune(cyc);
    model_clear();
    m_id = id; m_num = num; m_loaded = 1'b1;
    m_dly = (dly == 0) ? 1 : ((dly > 15) ? 15 : dly);
    step();
    cfg_valid = 1'b0;
    in_flit = '0;
  endtask

  task automatic send(input int vc, input bit head, input bit tail, input int dst);
    cr_t e;
    int code;
    in_flit = 32'(1) | (32'(vc) << 1) | (32'(head) << 3) | (32'(tail) << 4) | (32'(dst) << 5);
    code = 0;
    if (head) begin
      if (dst != m_id) code = 3;
      else if (m_open[vc]) code = 2;
      m_open[vc] = !tail;
      if (tail && m_pkt < 1023) m_pkt++;
    end else if (m_open[vc]) begin
      if (tail) begin
        m_open[vc] = 1'b0;
        if (m_pkt < 1023) m_pkt++;
      end
    end else begin
      code = 1;
    end
    if (m_flit < 65535) m_flit++;
    if (m_code == 0) m_code = code;
    e.vc = vc;
    e.cyc = cyc + m_dly;
    exp_q.push_back(e);
    step();
    in_flit = '0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    in_flit = '0;
    prune(cyc);
    model_clear();
    m_loaded = 1'b0; m_num = 0; m_dly = 1;
    step();
    chk({tag, "_cr_valid"}, int'(cr_valid), 0);
    chk({tag, "_cr_vc"}, int'(cr_vc), 0);
    check_state(tag);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    m_dly = 1; m_id = 0; m_num = 0; m_loaded = 1'b0;
    model_clear();
    step();
    do_reset("reset");

    // Single-flit packet, delay 2
    cfg(3, 1, 2);
    send(1, 1, 1, 3);
    check_state("single");
    idle(4);

    // Interleaved 4-flit vc0 and 3-flit vc2 packets
    cfg(3, 2, 3);
    send(0, 1, 0, 3); send(2, 1, 0, 3); send(0, 0, 0, 3); send(2, 0, 0, 3);
    send(0, 0, 0, 3); send(2, 0, 1, 3); send(0, 0, 1, 3);
    check_state("interleave");
    idle(5);

    // Body on idle VC
    cfg(3, 5, 1);
    send(1, 0, 0, 3);
    check_state("orphan_body");
    idle(3);

    // Head inside open packet, then tail closes it
    cfg(3, 1, 4);
    send(0, 1, 0, 3); send(0, 1, 0, 3);
    check_state("head_in_open");
    idle(2);
    send(0, 0, 1, 3);
    check_state("head_in_open_close");
    idle(6);

    // Bad destination first, later head-in-open keeps code 3
    cfg(3, 2, 2);
    send(0, 1, 0, 5); send(3, 1, 0, 3); send(3, 1, 0, 3);
    check_state("bad_dst");
    send(0, 0, 1, 3); send(3, 0, 1, 3);
    check_state("bad_dst_close");
    idle(4);

    // Delay boundaries: 0 behaves as 1, 15 is the maximum
    cfg(3, 1, 0);
    send(2, 1, 1, 3);
    check_state("dly0");
    idle(3);
    cfg(3, 2, 15);
    send(3, 1, 1, 3); send(1, 1, 1, 3);
    check_state("dly15");
    idle(18);

    // Zero expected packets, and a flit coinciding with cfg_valid is ignored
    in_flit = 32'(1) | (32'(1) << 3) | (32'(1) << 4) | (32'(3) << 5);
    cfg(3, 0, 1);
    check_state("num0_cfg_flit");
    idle(3);
    check_state("num0_idle");

    // Randomized traffic
    cfg(3, $urandom_range(0, 20), $urandom_range(0, 15));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        send($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 5 : 3);
      else idle(1);
      check_state("random");
    end
    idle(18);

    // pkt_count saturation
    cfg(3, 1023, 1);
    for (int i = 0; i < 1030; i++) send(i % 4, 1, 1, 3);
    check_state("pkt_sat");
    idle(3);

    // Reset with credits in flight on a delay-5 config
    cfg(3, 4, 5);
    send(1, 1, 0, 3); send(1, 0, 0, 3); send(1, 0, 0, 3);
    do_reset("mid_reset");
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check_state("post_reset");
    end
    cfg(3, 0, 1);
    check_state("post_reset_cfg");
    idle(3);

    chk("credit_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eject_sink.md
EJECT_SINK -- requirements
Module: eject_sink

Interface
REQ-001 Parameter MAXVC, default 4, number of virtual channels handled.
REQ-002 Parameter FLIT_W, default 32, staging-word width; field positions come from the shared package.
REQ-003 Parameter MAXDLY, default 15, largest supported credit delay.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 cfg_valid  input  1  one-cycle pulse that loads configuration and clears counters.
REQ-007 cfg_my_id  input  RouterBitSize  ID of the router this sink ejects from.
REQ-008 cfg_num_pkt  input  10  number of packets expected.
REQ-009 cfg_credit_delay  input  4  credit return delay in cycles, 1..MAXDLY.
REQ-010 in_flit  input  FLIT_W  ejection staging word; fields BufferFull, BufferVc, FlitHead, FlitTail, FlitDst.
REQ-011 cr_valid  output  1  credit pulse towards the router.
REQ-012 cr_vc  output  clog2(MAXVC)  VC the credit belongs to.
REQ-013 pkt_count  output  10  completed packets.
REQ-014 flit_count  output  16  accepted flits.
REQ-015 err  output  1  sticky protocol-error flag.
REQ-016 err_code  output  2  first error: 0 none, 1 body/tail with no open packet, 2 head inside open packet, 3 FlitDst != cfg_my_id.
REQ-017 done  output  1  expected traffic fully received.

Function
REQ-018 A flit is accepted in any cycle with in_flit BufferFull=1; there is no backpressure, because credits guarantee space.
REQ-019 Each VC has a two-state FSM, IDLE and OPEN.
REQ-020 Head flit transitions (from IDLE):
- Head with Tail=0: IDLE->OPEN.
- Head with Tail=1 (single-flit packet): stays IDLE and increments pkt_count.
REQ-021 Tail flit in OPEN: OPEN->IDLE and increments pkt_count.
REQ-022 Body flit in OPEN: stays OPEN.
REQ-023 Head flit in OPEN raises error code 2, restarts the packet, and leaves the state as OPEN (or IDLE if Tail=1).
REQ-024 Non-head flit in IDLE raises error code 1, is counted in flit_count, does not change state, and does not count a packet.
REQ-025 FlitDst is checked on head flits only; a mismatch raises code 3 and the packet is still tracked.
REQ-026 err_code latches the first error only; when several errors coincide, priority is 3 > 2 > 1.
REQ-027 Every accepted flit increments flit_count; the counter saturates at 0xFFFF.
REQ-028 pkt_count saturates at 1023.
REQ-029 Every accepted flit, including erroneous ones, generates exactly one credit on its BufferVc.
REQ-030 That credit appears as cr_valid=1 exactly cfg_credit_delay cycles after acceptance, with cr_vc equal to the flit's VC.
REQ-031 A cfg_credit_delay value of 0 is treated as 1; values above MAXDLY are clamped to MAXDLY.
REQ-032 Credits are pipelined: one flit per cycle yields one credit per cycle, with none lost or merged.
REQ-033 done=1 when pkt_count == cfg_num_pkt and all VCs are IDLE; done is re-evaluated every cycle.
REQ-034 When cfg_num_pkt=0, done asserts the cycle after cfg_valid.
REQ-035 cfg_valid clears counters, err, err_code and the VC FSMs, and flushes in-flight credits.
REQ-036 A flit presented in the same cycle as cfg_valid is ignored.

Reset
REQ-037 While rst_n=0 at posedge, all outputs are 0 next cycle: cr_valid, cr_vc, pkt_count, flit_count, err, err_code, done.
REQ-038 Reset also sets every VC FSM to IDLE, empties the credit pipeline, and sets cfg_credit_delay storage to 1 and cfg_num_pkt to 0.
REQ-039 Reset mid-packet discards partial packets and pending credits, and no credit is emitted afterwards for flits accepted before reset.

Structure
REQ-040 The shared package holds the FlitHead/FlitTail/FlitDst/BufferFull/BufferVc field ranges, the RouterBitSize and maxvc constants, and the err_code enumeration.
REQ-041 One sub-module, credit_delay_line, holds the MAXDLY-deep valid+vc shift register with a programmable tap.

Verification
REQ-042 cfg(id=3, pkt=1, dly=2), then head+tail flit on vc1 dst3 at cycle 0 -> cr_valid at cycle 2 with cr_vc=1, pkt_count=1, done=1, err=0.
REQ-043 4-flit packet on vc0 interleaved with a 3-flit packet on vc2, one flit per cycle -> pkt_count=2, flit_count=7, seven consecutive credits with matching VCs, no error.
REQ-044 Body flit on idle vc1 -> err=1, err_code=1, one credit returned, pkt_count=0.
REQ-045 Head vc0, then head vc0 again -> err_code=2; a later tail closes the packet and pkt_count=1.
REQ-046 Head with dst=5 while my_id=3, then a later head on vc3 inside an open packet -> err_code stays 3.
REQ-047 Reset with 3 credits in flight on a dly=5 config -> no cr_valid after reset, all counters 0, done=0 until the next cfg_valid.
